// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared definitions for the SPI command sequencer.
//   - opcode constants OP_SET_X .. OP_FILL_RUN
//   - opcode/payload bit-field positions within the 24-bit command word
//   - FSM state enum (S_FILL exists only when SPI_CMD_FILL_EN is defined)
//   - helpers to split a command word into opcode and payload
package spi_cmd_pkg;

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned OP_MSB = 23;
  localparam int unsigned OP_LSB = 16;
  localparam int unsigned PL_MSB = 15;
  localparam int unsigned PL_LSB = 0;

  localparam logic [7:0] OP_SET_X       = 8'h01;
  localparam logic [7:0] OP_SET_Y       = 8'h02;
  localparam logic [7:0] OP_WRITE_PIXEL = 8'h03;
  localparam logic [7:0] OP_FILL_COLOR  = 8'h04;
  localparam logic [7:0] OP_FILL_RUN    = 8'h05;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WRITE  = 2'd2
`ifdef SPI_CMD_FILL_EN
    ,
    S_FILL   = 2'd3
`endif
  } state_t;

  function automatic logic [7:0] cmd_op(input logic [CMD_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [15:0] cmd_pl(input logic [CMD_W-1:0] w);
    return w[PL_MSB:PL_LSB];
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: command input and frame-buffer write bus of spi_cmd_ctrl.
//   i_cmd_data/i_cmd_vld : 24-bit command word with one-cycle valid
//   o_wr_req/o_wr_addr/o_wr_data/i_wr_ack : frame-buffer write handshake
// Signal names are from the controller's point of view.
//   slave  : the controller (spi_cmd_ctrl)
//   master : the environment (SPI receiver + frame-buffer port)
interface spi_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 17
);
  logic [23:0]       i_cmd_data;
  logic              i_cmd_vld;
  logic              o_wr_req;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              i_wr_ack;

  modport slave (
    input  i_cmd_data, i_cmd_vld, i_wr_ack,
    output o_wr_req, o_wr_addr, o_wr_data
  );

  modport master (
    output i_cmd_data, i_cmd_vld, i_wr_ack,
    input  o_wr_req, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous FIFO with full/empty flags.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write side (ignored when full)
//   i_pop, o_data  : read side, o_data is the head word (show-ahead)
//   o_full, o_empty: status flags
module spi_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command sequencer between the SPI receiver and the
// frame-buffer write port. Buffers 24-bit command words, decodes them,
// tracks a pixel cursor and issues req/ack writes (single pixels and,
// when SPI_CMD_FILL_EN is defined, run-length fills).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : command input and frame-buffer write handshake
//   o_busy         : registered, FIFO non-empty or FSM not idle
//   o_ovf          : sticky, a command word was dropped (FIFO full)
//   o_err_cmd      : one-cycle pulse, unknown opcode / coordinate out of range
// Configuration macro: SPI_CMD_FILL_EN (fill colour, run counter, FILL state).
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned H_RES      = 480,
  parameter int unsigned V_RES      = 272,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  spi_cmd_ctrl_if.slave  bus,
  output logic           o_busy,
  output logic           o_ovf,
  output logic           o_err_cmd
);
  localparam int unsigned X_W = $clog2(H_RES);
  localparam int unsigned Y_W = $clog2(V_RES);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [X_W-1:0]    X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]    Y_ONE    = Y_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CMD_W-1:0]  r_cmd;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_busy;
  logic              r_ovf;
`ifdef SPI_CMD_FILL_EN
  logic [15:0]       r_fill_color;
  logic [15:0]       r_run;
  logic              w_set_fc;
  logic              w_load_run;
  logic              w_run_dec;
`endif

  logic [CMD_W-1:0]  w_fifo_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_err;
  logic              w_set_x;
  logic              w_set_y;
  logic              w_load_pix;
  logic              w_advance;
  logic              w_req;
  logic [7:0]        w_op;
  logic [15:0]       w_pl;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(32'(y) * H_RES + 32'(x));
  endfunction

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (bus.i_cmd_vld),
    .i_data  (bus.i_cmd_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_op = cmd_op(r_cmd);
  assign w_pl = cmd_pl(r_cmd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_set_x     = 1'b0;
    w_set_y     = 1'b0;
    w_load_pix  = 1'b0;
    w_advance   = 1'b0;
    w_req       = 1'b0;
`ifdef SPI_CMD_FILL_EN
    w_set_fc    = 1'b0;
    w_load_run  = 1'b0;
    w_run_dec   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_IDLE;
        case (w_op)
          OP_SET_X: begin
            if (32'(w_pl) < H_RES) w_set_x = 1'b1;
            else                   w_err   = 1'b1;
          end
          OP_SET_Y: begin
            if (32'(w_pl) < V_RES) w_set_y = 1'b1;
            else                   w_err   = 1'b1;
          end
          OP_WRITE_PIXEL: begin
            w_load_pix  = 1'b1;
            w_state_nxt = S_WRITE;
          end
`ifdef SPI_CMD_FILL_EN
          OP_FILL_COLOR: w_set_fc = 1'b1;
          OP_FILL_RUN: begin
            w_load_run = 1'b1;
            if (w_pl != '0) w_state_nxt = S_FILL;
          end
`else
          OP_FILL_COLOR, OP_FILL_RUN: w_err = 1'b1;
`endif
          default: w_err = 1'b1;
        endcase
      end
      S_WRITE: begin
        w_req = 1'b1;
        if (bus.i_wr_ack) begin
          w_advance   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef SPI_CMD_FILL_EN
      S_FILL: begin
        w_req = 1'b1;
        if (bus.i_wr_ack) begin
          w_advance = 1'b1;
          w_run_dec = 1'b1;
          if (r_run == 16'd1) w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cursor and address move together; a linear step of +1 covers the row
  // wrap, only the last pixel of the frame needs an explicit return to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef SPI_CMD_FILL_EN
      r_fill_color <= '0;
      r_run        <= '0;
`endif
    end else begin
      r_busy <= !w_fifo_empty || (r_state != S_IDLE);
      // Full is judged at the start of the cycle, so a same-cycle pop
      // does not rescue the incoming word.
      if (bus.i_cmd_vld && w_fifo_full) r_ovf <= 1'b1;
      if (w_pop) r_cmd <= w_fifo_data;
      if (w_set_x) begin
        r_x    <= X_W'(w_pl);
        r_addr <= lin_addr(X_W'(w_pl), r_y);
      end
      if (w_set_y) begin
        r_y    <= Y_W'(w_pl);
        r_addr <= lin_addr(r_x, Y_W'(w_pl));
      end
      if (w_load_pix) r_data <= w_pl;
      if (w_advance) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          if (r_y == Y_LAST) begin
            r_y    <= '0;
            r_addr <= '0;
          end else begin
            r_y    <= r_y + Y_ONE;
            r_addr <= r_addr + ADDR_ONE;
          end
        end else begin
          r_x    <= r_x + X_ONE;
          r_addr <= r_addr + ADDR_ONE;
        end
      end
`ifdef SPI_CMD_FILL_EN
      if (w_set_fc) r_fill_color <= w_pl;
      if (w_load_run) begin
        r_run  <= w_pl;
        r_data <= r_fill_color;
      end
      if (w_run_dec) r_run <= r_run - 16'd1;
`endif
    end
  end

  assign bus.o_wr_req  = w_req;
  assign bus.o_wr_addr = r_addr;
  assign bus.o_wr_data = r_data;
  assign o_busy        = r_busy;
  assign o_ovf         = r_ovf;
  assign o_err_cmd     = w_err;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, ovf, err;

  spi_cmd_ctrl_if #(.ADDR_W(17)) bus();

  spi_cmd_ctrl #(
    .H_RES      (480),
    .V_RES      (272),
    .FIFO_DEPTH (4),
    .ADDR_W     (17)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .o_busy    (busy),
    .o_ovf     (ovf),
    .o_err_cmd (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int err_cnt = 0;
  int req_cnt = 0;
  int unsigned q_addr[$];
  int unsigned q_data[$];
  int unsigned q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log completed transfers, error pulses and request cycles.
  always @(negedge clk) begin
    if (bus.o_wr_req === 1'b1 && bus.i_wr_ack === 1'b1) begin
      q_addr.push_back(int'(bus.o_wr_addr));
      q_data.push_back(int'(bus.o_wr_data));
      q_cyc.push_back(cyc);
    end
    if (err === 1'b1) err_cnt++;
    if (bus.o_wr_req === 1'b1) req_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    err_cnt = 0;
    req_cnt = 0;
  endtask

  task automatic send(input logic [23:0] w);
    bus.i_cmd_data = w;
    bus.i_cmd_vld  = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_vld  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus.o_wr_req === 1'b0) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_idle: busy=%b, required 0 within bound", tag, busy);
    end
  endtask

  task automatic test_reset();
    bus.i_cmd_vld = 1'b0; bus.i_cmd_data = '0; bus.i_wr_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_wr_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b required 0", bus.o_wr_req); end
    checks++; if (bus.o_wr_addr !== 17'd0) begin failures++; $display("FAIL rst_addr: got %0d required 0", bus.o_wr_addr); end
    checks++; if (bus.o_wr_data !== 16'h0000) begin failures++; $display("FAIL rst_data: got %h required 0000", bus.o_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b required 0", ovf); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b required 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_write_pixel();
    int unsigned t0;
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h01000A);
    send(24'h020002);
    send(24'h03F800);
    wait_idle("wp");
    checks++; if (q_addr.size() != 1) begin failures++; $display("FAIL wp_count: got %0d writes required 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      checks++; if (q_addr[0] != 970) begin failures++; $display("FAIL wp_addr: got %0d required 970", q_addr[0]); end
      checks++; if (q_data[0] != 32'hF800) begin failures++; $display("FAIL wp_data: got %h required f800", q_data[0]); end
    end
    // Cursor now (11,2); single word into empty FIFO also checks latency.
    clear_log();
    t0 = cyc;
    send(24'h031234);
    wait_idle("wp2");
    checks++; if (q_addr.size() != 1) begin failures++; $display("FAIL wp2_count: got %0d writes required 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      checks++; if (q_addr[0] != 971) begin failures++; $display("FAIL wp2_addr: got %0d required 971", q_addr[0]); end
      checks++; if (q_cyc[0] != t0 + 3) begin failures++; $display("FAIL wp2_latency: got cycle %0d required %0d", q_cyc[0], t0 + 3); end
      checks++; if (q_data[0] != 32'h1234) begin failures++; $display("FAIL wp2_data: got %h required 1234", q_data[0]); end
    end
  endtask

  task automatic test_wrap();
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h0101DF);
    send(24'h02010F);
    send(24'h03001F);
    send(24'h0307E0);
    wait_idle("wrap");
    checks++; if (q_addr.size() != 2) begin failures++; $display("FAIL wrap_count: got %0d writes required 2", q_addr.size()); end
    if (q_addr.size() >= 2) begin
      checks++; if (q_addr[0] != 130559) begin failures++; $display("FAIL wrap_addr0: got %0d required 130559", q_addr[0]); end
      checks++; if (q_data[0] != 32'h001F) begin failures++; $display("FAIL wrap_data0: got %h required 001f", q_data[0]); end
      checks++; if (q_addr[1] != 0) begin failures++; $display("FAIL wrap_addr1: got %0d required 0", q_addr[1]); end
      checks++; if (q_data[1] != 32'h07E0) begin failures++; $display("FAIL wrap_data1: got %h required 07e0", q_data[1]); end
    end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL wrap_err: got %0d pulses required 0", err_cnt); end
  endtask

`ifdef SPI_CMD_FILL_EN
  task automatic test_fill();
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h010000);
    send(24'h020000);
    send(24'h04FFFF);
    send(24'h050005);
    wait_idle("fill");
    checks++; if (q_addr.size() != 5) begin failures++; $display("FAIL fill_count: got %0d writes required 5", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 5; i++) begin
      checks++;
      if (q_addr[i] != i || q_data[i] != 32'hFFFF || q_cyc[i] != q_cyc[0] + i) begin
        failures++;
        $display("FAIL fill_beat%0d: got addr %0d data %h cycle +%0d required addr %0d data ffff cycle +%0d",
                 i, q_addr[i], q_data[i], q_cyc[i] - q_cyc[0], i, i);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_busy: got %b required 0", busy); end
    // Zero-length run is a no-op.
    clear_log();
    send(24'h050000);
    wait_idle("fill0");
    checks++; if (req_cnt != 0 || err_cnt != 0) begin failures++; $display("FAIL fill0: got %0d req cycles %0d err required 0 0", req_cnt, err_cnt); end
  endtask

  task automatic test_fill_stall();
    logic [16:0] a;
    logic [15:0] d;
    bus.i_wr_ack = 1'b0;
    clear_log();
    send(24'h010064);
    send(24'h04ABCD);
    send(24'h050003);
    for (int i = 0; i < 3; i++) begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (bus.o_wr_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || bus.o_wr_addr !== 17'(100 + i) || bus.o_wr_data !== 16'hABCD) begin
        failures++;
        $display("FAIL stall_present%0d: got req %b addr %0d data %h required 1 %0d abcd",
                 i, bus.o_wr_req, bus.o_wr_addr, bus.o_wr_data, 100 + i);
      end
      a = bus.o_wr_addr;
      d = bus.o_wr_data;
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        checks++;
        if (bus.o_wr_req !== 1'b1 || bus.o_wr_addr !== a || bus.o_wr_data !== d) begin
          failures++;
          $display("FAIL stall_hold%0d_%0d: got req %b addr %0d data %h required 1 %0d %h",
                   i, s, bus.o_wr_req, bus.o_wr_addr, bus.o_wr_data, a, d);
        end
      end
      @(posedge clk); #1; bus.i_wr_ack = 1'b1;
      @(posedge clk); #1; bus.i_wr_ack = 1'b0;
    end
    wait_idle("stall");
    checks++; if (q_addr.size() != 3) begin failures++; $display("FAIL stall_count: got %0d writes required 3", q_addr.size()); end
    if (q_addr.size() >= 3) begin
      checks++;
      if (q_addr[0] != 100 || q_addr[1] != 101 || q_addr[2] != 102) begin
        failures++;
        $display("FAIL stall_addrs: got %0d %0d %0d required 100 101 102", q_addr[0], q_addr[1], q_addr[2]);
      end
    end
  endtask
`else
  task automatic test_fill_disabled();
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h04FFFF);
    send(24'h050005);
    wait_idle("nofill");
    checks++; if (err_cnt != 2) begin failures++; $display("FAIL nofill_err: got %0d pulses required 2", err_cnt); end
    checks++; if (req_cnt != 0) begin failures++; $display("FAIL nofill_req: got %0d req cycles required 0", req_cnt); end
  endtask
`endif

  task automatic test_overflow();
    bus.i_wr_ack = 1'b0;
    clear_log();
    send(24'h010000);
    send(24'h020001);
    wait_idle("ovf_setup");
    clear_log();
    for (int i = 1; i <= 5; i++) send(24'h030000 | 24'(i));
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b required 0", ovf); end
    send(24'h030006);
    @(negedge clk);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1", ovf); end
    @(posedge clk); #1;
    bus.i_wr_ack = 1'b1;
    wait_idle("ovf");
    checks++; if (q_addr.size() != 5) begin failures++; $display("FAIL ovf_count: got %0d writes required 5", q_addr.size()); end
    for (int i = 0; i < q_addr.size() && i < 5; i++) begin
      checks++;
      if (q_addr[i] != 480 + i || q_data[i] != i + 1) begin
        failures++;
        $display("FAIL ovf_write%0d: got addr %0d data %h required %0d %h", i, q_addr[i], q_data[i], 480 + i, i + 1);
      end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
  endtask

  task automatic test_err();
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h7F0000);
    send(24'h0101E0);
    send(24'h020110);
    wait_idle("err");
    checks++; if (err_cnt != 3) begin failures++; $display("FAIL err_pulses: got %0d required 3", err_cnt); end
    checks++; if (req_cnt != 0) begin failures++; $display("FAIL err_req: got %0d req cycles required 0", req_cnt); end
    // Cursor must still be (5,1).
    clear_log();
    send(24'h035555);
    wait_idle("err_cur");
    checks++;
    if (q_addr.size() != 1 || q_addr[0] != 485) begin
      failures++;
      $display("FAIL err_cursor: got %0d writes first addr %0d required 1 485",
               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.i_wr_ack = 1'b0;
    clear_log();
    send(24'h03AAAA);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_wr_req === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_req: got 0 required 1 before reset"); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_wr_req !== 1'b0) begin failures++; $display("FAIL rmid_drop: got %b required 0", bus.o_wr_req); end
    checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_flags: got ovf %b busy %b required 0 0", ovf, busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_wr_ack = 1'b1;
    clear_log();
    send(24'h03BEEF);
    wait_idle("rmid");
    checks++;
    if (q_addr.size() != 1 || q_addr[0] != 0 || q_data[0] != 32'hBEEF) begin
      failures++;
      $display("FAIL rmid_after: got %0d writes addr %0d required 1 write addr 0 data beef",
               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 0);
    end
  endtask

  initial begin
    test_reset();
    test_write_pixel();
    test_wrap();
`ifdef SPI_CMD_FILL_EN
    test_fill();
    test_fill_stall();
`else
    test_fill_disabled();
`endif
    test_overflow();
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer between the SPI slave receiver and the frame-buffer write port. Accepts 24-bit words (8-bit opcode + 16-bit payload) with their one-cycle valid pulse, buffers them in a small FIFO, and decodes them. It tracks a pixel cursor (x, y) and issues frame-buffer write requests over a req/ack handshake, including run-length fills. Sits in the `i_clk` domain directly downstream of the SPI receive block.

## Interface
- `H_RES`, 480, display width in pixels.
- `V_RES`, 272, display height in pixels.
- `FIFO_DEPTH`, 4, command FIFO depth; power of two, ≥2.
- `ADDR_W`, 17, frame-buffer address width; must satisfy H_RES*V_RES ≤ 2^ADDR_W.
- `i_clk`  in  1  system clock; sole clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_cmd_data`  in  24  received word; [23:16] opcode, [15:0] payload.
- `i_cmd_vld`  in  1  one-cycle valid pulse for `i_cmd_data`.
- `o_wr_req`  out  1  frame-buffer write request.
- `o_wr_addr`  out  ADDR_W  linear pixel address, y*H_RES + x.
- `o_wr_data`  out  16  RGB565 pixel.
- `i_wr_ack`  in  1  write accepted this cycle.
- `o_busy`  out  1  FIFO non-empty or FSM not IDLE.
- `o_ovf`  out  1  sticky: a word was dropped because the FIFO was full.
- `o_err_cmd`  out  1  one-cycle pulse: unknown opcode, or coordinate out of range.

## Operation
- Reset: all outputs 0; x = y = 0; fill colour 0x0000; FIFO empty; FSM IDLE.
- FIFO push on `i_cmd_vld`. If the FIFO is full at the start of the cycle, the word is dropped and `o_ovf` is set, even if a pop occurs in the same cycle.
- FSM states: IDLE, DECODE, WRITE, FILL.
  - IDLE → DECODE when the FIFO is non-empty; the word is popped.
  - DECODE executes the opcode:
    - 0x01 SET_X: x = payload. If payload ≥ H_RES, the command is ignored and `o_err_cmd` pulses. → IDLE.
    - 0x02 SET_Y: y = payload. If payload ≥ V_RES, the command is ignored and `o_err_cmd` pulses. → IDLE.
    - 0x03 WRITE_PIXEL: load `o_wr_data` = payload and `o_wr_addr` from the cursor. → WRITE.
    - 0x04 FILL_COLOR: fill colour = payload. → IDLE.
    - 0x05 FILL_RUN: run counter = payload. → FILL if the count is nonzero; → IDLE if zero (no-op).
    - Any other opcode: `o_err_cmd` pulses. → IDLE.
  - WRITE: hold `o_wr_req` = 1 until `i_wr_ack`. On ack, advance the cursor. → IDLE.
  - FILL: drive the fill colour with `o_wr_req` = 1. Each ack advances the cursor and decrements the counter. → IDLE on the ack that brings the counter to 0.
- Cursor advance:
  - x+1.
  - At x = H_RES-1: x = 0, y+1.
  - At (H_RES-1, V_RES-1): wraps to (0, 0).
- Address: registered y*H_RES + x, updated in the same cycle as the cursor change.
- New words arriving during WRITE/FILL are buffered, not executed.

## Timing
- `i_cmd_vld` at cycle 0 into an empty FIFO in IDLE:
  - pop in cycle 1;
  - DECODE in cycle 2;
  - `o_wr_req` high from cycle 3.
- Handshake:
  - `o_wr_addr` and `o_wr_data` are stable while `o_wr_req` = 1 and `i_wr_ack` = 0.
  - Transfer completes in the cycle `i_wr_ack` = 1.
  - `i_wr_ack` while `o_wr_req` = 0 is ignored.
- FILL runs back-to-back: `o_wr_req` stays high, and the next address and data are presented in the cycle after each ack. Throughput is one pixel per cycle with continuous ack.
- `o_err_cmd` pulses in the DECODE cycle.
- `o_busy` is registered and follows FIFO/FSM state with a 1-cycle delay.
- Reset asserted mid-fill: `o_wr_req` drops immediately (asynchronous); the remaining count and FIFO contents are discarded.

## Configuration
- `SPI_CMD_FILL_EN` defined: opcodes 0x04/0x05 and the FILL state are implemented as above.
- Undefined:
  - the fill colour register, run counter and FILL state are absent;
  - 0x04/0x05 are treated as unknown opcodes (`o_err_cmd` pulses, no write).

## Structure
- Package `spi_cmd_pkg`: opcode constants (OP_SET_X … OP_FILL_RUN), FSM state enum, and the opcode/payload bit-field positions.
- Sub-module `spi_cmd_fifo`: synchronous FIFO, depth FIFO_DEPTH, width 24, with full/empty flags; same clock and reset.

## Test plan
- SET_X 10, SET_Y 2, WRITE_PIXEL 0xF800 → one write: addr 970, data 0xF800; then cursor at (11, 2).
- SET_X 479, SET_Y 271, WRITE_PIXEL 0x001F, WRITE_PIXEL 0x07E0 → addr 130559, then addr 0.
- FILL_COLOR 0xFFFF, FILL_RUN 5 with ack held high → 5 consecutive-cycle writes at addr 0..4; then IDLE, `o_busy` → 0.
- FILL_RUN 3 with ack stalled for 4 cycles before each acceptance → addr/data stable during stalls; exactly 3 writes.
- Ack held low, 6 back-to-back WRITE_PIXEL words → 5 accepted (1 in FSM + 4 in FIFO), 6th dropped, `o_ovf` = 1.
- Opcode 0x7F, and SET_X 480 → `o_err_cmd` pulses twice; x unchanged; no write request.
